// File: rtl/regfile_pkg.sv
// Shared register-file definitions for the writeback arbiter and its scoreboard.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // Which requester owns the write port this cycle
    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_A,
        WIN_B
    } win_e;

    // Arbitration situation derived each cycle from the valids and the starvation force
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_A_WIN,
        ARB_B_WIN,
        ARB_B_FORCED
    } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: bit n set means register n still awaits a multi-cycle result.
// A set and a clear of the same bit in one cycle leaves the bit set, since a newer op
// has claimed the register. Bit 0 is tied off because register 0 is never written.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Decode the set and clear requests into one-hot masks
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_addr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
    end

    // Apply clear first and set last so a fresh issue wins, keeping bit 0 at zero
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage (A) and a
// multi-cycle unit (B), and tracks registers awaiting B results. A normally has priority;
// when WB_ARB_STARVE_EN is defined, B is forced through after STARVE_LIMIT blocked cycles.
// Without WB_ARB_STARVE_EN the starvation counter is not built and A has strict priority.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [REG_ADDR_W-1:0] a_addr_i,
    input  logic [REG_DATA_W-1:0] a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [REG_ADDR_W-1:0] b_addr_i,
    input  logic [REG_DATA_W-1:0] b_data_i,
    input  logic                  iss_valid_i,
    input  logic [REG_ADDR_W-1:0] iss_addr_i,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic                  regwrite_o,
    output logic [REG_ADDR_W-1:0] writeaddr_o,
    output logic [REG_DATA_W-1:0] writedata_o,
    output logic                  grant_b_o
);

    logic       force_b;
    logic       a_hs;
    logic       b_hs;
    arb_state_e arb_state;
    win_e       winner;
    reg_addr_t  sel_addr;
    reg_data_t  sel_data;

`ifdef WB_ARB_STARVE_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;

    // Force is masked during reset so A always looks ready while reset is held
    assign force_b = rst_i && (wait_cnt >= LIMIT);

    // Count consecutive cycles in which B wants the port but is held off
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (!b_valid_i || b_hs) begin
            wait_cnt <= '0;
        end else if (wait_cnt < LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // The sizing parameters only matter when the guard is built; this is constant zero
    assign force_b = (STARVE_LIMIT < 0) && (CNT_W < 0);
`endif

    assign a_ready_o = !force_b;
    assign b_ready_o = force_b || !a_valid_i;

    // Classify the cycle and pick the requester that handshakes
    always_comb begin
        arb_state = ARB_IDLE;
        if (force_b) begin
            if (b_valid_i) arb_state = ARB_B_FORCED;
        end else if (a_valid_i) begin
            arb_state = ARB_A_WIN;
        end else if (b_valid_i) begin
            arb_state = ARB_B_WIN;
        end

        winner = WIN_NONE;
        case (arb_state)
            ARB_A_WIN:                winner = WIN_A;
            ARB_B_WIN, ARB_B_FORCED:  winner = WIN_B;
            default:                  winner = WIN_NONE;
        endcase
    end

    assign a_hs     = (winner == WIN_A);
    assign b_hs     = (winner == WIN_B);
    assign sel_addr = b_hs ? b_addr_i : a_addr_i;
    assign sel_data = b_hs ? b_data_i : a_data_i;

    // Register the winning write; register 0 handshakes but never raises the enable
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            regwrite_o  <= 1'b0;
            grant_b_o   <= 1'b0;
            writeaddr_o <= '0;
            writedata_o <= '0;
        end else begin
            regwrite_o <= (winner != WIN_NONE) && (sel_addr != '0);
            if (winner != WIN_NONE) begin
                writeaddr_o <= sel_addr;
                writedata_o <= sel_data;
                grant_b_o   <= b_hs;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (iss_valid_i && (iss_addr_i != '0)),
        .set_addr_i (iss_addr_i),
        .clr_en_i   (b_hs),
        .clr_addr_i (b_addr_i),
        .busy_o     (busy_o)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter; follows WB_ARB_STARVE_EN the same way the design does.
module tb_regfile_wb_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i, b_valid_i, iss_valid_i;
    logic        a_ready_o, b_ready_o;
    logic [4:0]  a_addr_i, b_addr_i, iss_addr_i;
    logic [31:0] a_data_i, b_data_i;
    logic [31:0] busy_o;
    logic        regwrite_o, grant_b_o;
    logic [4:0]  writeaddr_o;
    logic [31:0] writedata_o;

    int total = 0;
    int bad   = 0;

    // Reference model: what the register-file port and scoreboard should show
    logic [31:0] m_busy = '0;
    logic        m_regwrite = 1'b0;
    logic        m_grant = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_blocked = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
        .iss_valid_i(iss_valid_i), .iss_addr_i(iss_addr_i), .busy_o(busy_o),
        .regwrite_o(regwrite_o), .writeaddr_o(writeaddr_o), .writedata_o(writedata_o),
        .grant_b_o(grant_b_o)
    );

    always #5 clk_i = ~clk_i;

    // B is pushed through once it has been refused STARVE_LIMIT cycles in a row
    function automatic bit m_force();
        return STARVE_EN && rst_i && (m_blocked >= STARVE_LIMIT);
    endfunction

    function automatic bit m_a_ready();
        return !m_force();
    endfunction

    function automatic bit m_b_ready();
        return m_force() || !a_valid_i;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then step the DUT
    task automatic advance();
        bit ah, bh;
        ah = a_valid_i && m_a_ready();
        bh = b_valid_i && m_b_ready();
        if (!rst_i) begin
            m_busy = '0; m_regwrite = 1'b0; m_grant = 1'b0;
            m_addr = '0; m_data = '0; m_blocked = 0;
        end else begin
            m_regwrite = 1'b0;
            if (ah) begin
                m_regwrite = (a_addr_i != 0); m_addr = a_addr_i; m_data = a_data_i; m_grant = 1'b0;
            end else if (bh) begin
                m_regwrite = (b_addr_i != 0); m_addr = b_addr_i; m_data = b_data_i; m_grant = 1'b1;
            end
            if (bh) m_busy[b_addr_i] = 1'b0;
            if (iss_valid_i && iss_addr_i != 0) m_busy[iss_addr_i] = 1'b1;
            if (!b_valid_i || bh) m_blocked = 0;
            else if (m_blocked < STARVE_LIMIT) m_blocked++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid_i = 0; b_valid_i = 0; iss_valid_i = 0;
        a_addr_i = '0; b_addr_i = '0; iss_addr_i = '0;
        a_data_i = '0; b_data_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        advance();
        advance();
        total++; if (regwrite_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_regwrite: got %0b expected 0", regwrite_o); end
        total++; if (busy_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_busy: got %h expected 0", busy_o); end
        total++; if (writeaddr_o !== 5'd0 || writedata_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr_data: got %0d/%h expected 0/0", writeaddr_o, writedata_o); end
        total++; if (grant_b_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_grant: got %0b expected 0", grant_b_o); end
        total++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %0b/%0b expected 1/1", a_ready_o, b_ready_o); end
        rst_i = 1'b1;
        advance();
    endtask

    task automatic test_single_a();
        a_valid_i = 1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
        #1;
        total++; if (a_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL single_a_ready: got %0b expected 1", a_ready_o); end
        advance();
        a_valid_i = 0;
        total++; if (regwrite_o !== 1'b1 || writeaddr_o !== 5'd5 || writedata_o !== 32'hDEADBEEF || grant_b_o !== 1'b0)
            begin bad++; $display("[TB] FAIL single_a_write: got we=%0b a=%0d d=%h gb=%0b expected 1/5/deadbeef/0", regwrite_o, writeaddr_o, writedata_o, grant_b_o); end
        advance();
        total++; if (regwrite_o !== 1'b0) begin bad++; $display("[TB] FAIL single_a_drop: got %0b expected 0", regwrite_o); end
    endtask

    task automatic test_contention();
        bit exp_force;
        a_valid_i = 1; a_addr_i = 5'd3; a_data_i = 32'hA000_0000;
        b_valid_i = 1; b_addr_i = 5'd4; b_data_i = 32'hB000_0004;
        for (int c = 0; c < 10; c++) begin
            exp_force = STARVE_EN && (c == 4 || c == 9);
            #1;
            total++; if (a_ready_o !== !exp_force || b_ready_o !== exp_force)
                begin bad++; $display("[TB] FAIL contention_ready[%0d]: got %0b/%0b expected %0b/%0b", c, a_ready_o, b_ready_o, !exp_force, exp_force); end
            advance();
            total++; if (regwrite_o !== 1'b1 || grant_b_o !== exp_force || writeaddr_o !== (exp_force ? 5'd4 : 5'd3))
                begin bad++; $display("[TB] FAIL contention_grant[%0d]: got we=%0b gb=%0b a=%0d expected 1/%0b/%0d", c, regwrite_o, grant_b_o, writeaddr_o, exp_force, exp_force ? 4 : 3); end
            if (!exp_force) a_data_i = a_data_i + 1;
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_scoreboard();
        iss_valid_i = 1; iss_addr_i = 5'd7;
        advance();
        iss_valid_i = 0;
        total++; if (busy_o[7] !== 1'b1) begin bad++; $display("[TB] FAIL sb_set: got %0b expected 1", busy_o[7]); end
        b_valid_i = 1; b_addr_i = 5'd7; b_data_i = 32'h12;
        #1;
        total++; if (b_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL sb_b_ready: got %0b expected 1", b_ready_o); end
        advance();
        b_valid_i = 0;
        total++; if (busy_o[7] !== 1'b0 || regwrite_o !== 1'b1 || writeaddr_o !== 5'd7 || writedata_o !== 32'h12 || grant_b_o !== 1'b1)
            begin bad++; $display("[TB] FAIL sb_clear_write: got busy=%0b we=%0b a=%0d d=%h gb=%0b expected 0/1/7/12/1", busy_o[7], regwrite_o, writeaddr_o, writedata_o, grant_b_o); end
    endtask

    task automatic test_collision();
        iss_valid_i = 1; iss_addr_i = 5'd9;
        advance();
        b_valid_i = 1; b_addr_i = 5'd9; b_data_i = 32'h99;
        advance();
        iss_valid_i = 0;
        total++; if (busy_o[9] !== 1'b1) begin bad++; $display("[TB] FAIL collision_set_wins: got %0b expected 1", busy_o[9]); end
        advance();
        b_valid_i = 0;
        total++; if (busy_o[9] !== 1'b0) begin bad++; $display("[TB] FAIL collision_later_clear: got %0b expected 0", busy_o[9]); end
    endtask

    task automatic test_reg0();
        b_valid_i = 1; b_addr_i = 5'd0; b_data_i = 32'h55;
        iss_valid_i = 1; iss_addr_i = 5'd0;
        advance();
        b_valid_i = 0; iss_valid_i = 0;
        total++; if (regwrite_o !== 1'b0 || grant_b_o !== 1'b1 || busy_o[0] !== 1'b0)
            begin bad++; $display("[TB] FAIL reg0_b: got we=%0b gb=%0b busy0=%0b expected 0/1/0", regwrite_o, grant_b_o, busy_o[0]); end
        a_valid_i = 1; a_addr_i = 5'd0; a_data_i = 32'h66;
        advance();
        a_valid_i = 0;
        total++; if (regwrite_o !== 1'b0 || grant_b_o !== 1'b0 || busy_o[0] !== 1'b0)
            begin bad++; $display("[TB] FAIL reg0_a: got we=%0b gb=%0b busy0=%0b expected 0/0/0", regwrite_o, grant_b_o, busy_o[0]); end
    endtask

    task automatic test_reset_mid();
        a_valid_i = 1; a_addr_i = 5'd2; a_data_i = 32'h1;
        b_valid_i = 1; b_addr_i = 5'd20; b_data_i = 32'hB20;
        iss_valid_i = 1; iss_addr_i = 5'd7;
        advance();
        iss_addr_i = 5'd11;
        advance();
        iss_valid_i = 0;
        advance();
        total++; if (busy_o !== 32'h0000_0880) begin bad++; $display("[TB] FAIL mid_busy_setup: got %h expected 00000880", busy_o); end
        rst_i = 1'b0;
        a_addr_i = 5'd12; a_data_i = 32'hC0FFEE;
        #1;
        total++; if (a_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_a_ready: got %0b expected 1", a_ready_o); end
        advance();
        rst_i = 1'b1;
        total++; if (busy_o !== 32'h0 || regwrite_o !== 1'b0)
            begin bad++; $display("[TB] FAIL mid_reset_clear: got busy=%h we=%0b expected 0/0", busy_o, regwrite_o); end
        #1;
        total++; if (a_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_a_ready: got %0b expected 1", a_ready_o); end
        advance();
        total++; if (regwrite_o !== 1'b1 || writeaddr_o !== 5'd12 || writedata_o !== 32'hC0FFEE)
            begin bad++; $display("[TB] FAIL post_reset_write: got we=%0b a=%0d d=%h expected 1/12/c0ffee", regwrite_o, writeaddr_o, writedata_o); end
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        bit a_hold, b_hold;
        a_hold = 0; b_hold = 0;
        for (int n = 0; n < 400; n++) begin
            rst_i = ($urandom_range(0, 59) != 0);
            if (!a_hold) begin
                a_valid_i = ($urandom_range(0, 2) != 0);
                a_addr_i = 5'($urandom_range(0, 31)); a_data_i = $urandom;
            end
            if (!b_hold) begin
                b_valid_i = ($urandom_range(0, 1) != 0);
                b_addr_i = 5'($urandom_range(0, 31)); b_data_i = $urandom;
            end
            iss_valid_i = ($urandom_range(0, 3) == 0);
            iss_addr_i = 5'($urandom_range(0, 31));
            #1;
            total++; if (a_ready_o !== m_a_ready() || b_ready_o !== m_b_ready())
                begin bad++; $display("[TB] FAIL rand_ready[%0d]: got %0b/%0b expected %0b/%0b", n, a_ready_o, b_ready_o, m_a_ready(), m_b_ready()); end
            a_hold = rst_i && a_valid_i && !m_a_ready();
            b_hold = rst_i && b_valid_i && !m_b_ready();
            advance();
            total++; if (regwrite_o !== m_regwrite || writeaddr_o !== m_addr || writedata_o !== m_data || grant_b_o !== m_grant)
                begin bad++; $display("[TB] FAIL rand_port[%0d]: got we=%0b a=%0d d=%h gb=%0b expected %0b/%0d/%h/%0b", n, regwrite_o, writeaddr_o, writedata_o, grant_b_o, m_regwrite, m_addr, m_data, m_grant); end
            total++; if (busy_o !== m_busy)
                begin bad++; $display("[TB] FAIL rand_busy[%0d]: got %h expected %h", n, busy_o, m_busy); end
        end
        rst_i = 1'b1;
        idle_inputs();
        advance();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_scoreboard();
        test_collision();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
